// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  // One counter serves every state, so it must cover the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// retry, debounces lock, then releases the downstream synchronous reset.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked_in,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [7:0] retry_count,
  output logic [7:0] relock_count,
  output logic [2:0] state_dbg
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRIES);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    retry_nx, relock_nx;
  logic          locked_s;

  sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (locked_in),
    .q     (locked_s)
  );

  assign state_dbg = state;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CW'(1);
    retry_nx  = retry_count;
    relock_nx = relock_count;
    if (restart) begin
      state_nx = RESET_PLL;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end
        end
        WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (locked_s) begin
            state_nx = STABILIZE;
            cnt_nx   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_nx   = '0;
            retry_nx = (retry_count == RETRY_MAX) ? retry_count : retry_count + 8'd1;
            state_nx = (retry_nx == RETRY_MAX) ? FAILED : RESET_PLL;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nx = RUN;
            cnt_nx   = '0;
            retry_nx = '0;
          end
        end
        RUN: begin
          cnt_nx = '0;
          if (!locked_s) begin
            state_nx  = RESET_PLL;
            relock_nx = (relock_count == 8'hff) ? relock_count : relock_count + 8'd1;
          end
        end
        FAILED: begin
          cnt_nx = '0;
        end
        default: begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the entry edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET_PLL;
      cnt          <= '0;
      retry_count  <= '0;
      relock_count <= '0;
      pll_rst      <= 1'b1;
      sys_reset_n  <= 1'b0;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      retry_count  <= retry_nx;
      relock_count <= relock_nx;
      pll_rst      <= (state_nx == RESET_PLL);
      sys_reset_n  <= (state_nx == RUN);
      ready        <= (state_nx == RUN);
      fail         <= (state_nx == FAILED);
    end
  end

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Drives the `rst` input of a clock-generation PLL (e.g. the 48/54 MHz USB/video PLL) and consumes its `locked` output.
- Sequences the PLL reset, waits for lock with a timeout and retries, and debounces lock.
- Releases a synchronous system reset to downstream logic only after lock has been stable.
- Runs in the PLL reference-clock domain (50 MHz) and is instantiated next to the PLL wrapper in each board top level.

Parameters:
- RST_CYCLES, 16: width of the PLL reset pulse in clk cycles (>=1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive cycles synchronized lock must stay high before release.
- MAX_RETRIES, 7: number of timeouts tolerated before FAILED (1..255).

Ports:
- clk  in  1  reference clock (same clock that feeds the PLL refclk)
- reset_n  in  1  asynchronous active-low reset
- locked_in  in  1  PLL locked, asynchronous to clk
- restart  in  1  single-cycle pulse; restarts the sequence from RESET_PLL and clears retry_count
- pll_rst  out  1  active-high reset to the PLL
- sys_reset_n  out  1  active-low reset to downstream logic, synchronous to clk
- ready  out  1  high only in RUN
- fail  out  1  high only in FAILED
- retry_count  out  8  timeouts since last successful lock, saturating at MAX_RETRIES
- relock_count  out  8  lock losses seen in RUN, saturating at 255

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`reset_n`); all flops clear on assertion. Reset values: state=RESET_PLL, pll_rst=1, sys_reset_n=0, ready=0, fail=0, retry_count=0, relock_count=0, counters=0, sync flops=0.
- locked_in passes through a 2-flop synchronizer, giving locked_s. Latency is 2 cycles; all decisions use locked_s.
- All outputs are registered. They take their new value on the same edge the FSM enters the corresponding state.
- RESET_PLL: pll_rst=1, sys_reset_n=0. Stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK and clears the counter.
- WAIT_LOCK: pll_rst=0, sys_reset_n=0. The counter increments each cycle.
  - locked_s=1: go to STABILIZE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0: retry_count+1.
    - If the new value equals MAX_RETRIES, go to FAILED.
    - Otherwise go to RESET_PLL.
  - Lock takes priority over timeout on the same cycle.
- STABILIZE: pll_rst=0, sys_reset_n=0.
  - locked_s=0 on any cycle: go to WAIT_LOCK with a fresh timeout counter; retry_count unchanged.
  - After STABLE_CYCLES consecutive cycles with locked_s=1: go to RUN and clear retry_count.
- RUN: sys_reset_n=1, ready=1, pll_rst=0.
  - locked_s=0: go to RESET_PLL. On that same edge sys_reset_n=0, ready=0, and relock_count+1 (held at 255).
- FAILED: pll_rst=0, sys_reset_n=0, fail=1. Held until restart or reset_n.
- restart has priority over every transition, in every state.
  - Next state is RESET_PLL; counter and retry_count are cleared; relock_count is kept.
  - If restart arrives in RUN, sys_reset_n drops on the next edge; relock_count is not incremented.
- Glitch handling:
  - A lock glitch shorter than 1 cycle may be missed. That is acceptable.
  - Any glitch sampled by the synchronizer restarts the stabilization count.
- Counters are sized `$clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))` bits. One shared counter is reused per state.
- Release latency from a clean lock: locked_in rise to sys_reset_n rise = 2 (sync) + 1 (WAIT_LOCK exit) + STABLE_CYCLES cycles.

Decomposition:
- Package pll_reset_pkg:
  - State enum {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAILED}, 3-bit encoding.
  - Counter-width helper function.
- Sub-module sync_2ff: generic 2-flop synchronizer, async active-low reset, reset value parameter. It is reused elsewhere in the codebase.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3):
- Power-up with locked_in rising 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_reset_n rises exactly 2+1+8=11 cycles after locked_in rises; ready=1; retry_count=0.
- locked_in held 0 -> three 20-cycle WAIT_LOCK windows, each separated by a 4-cycle pll_rst pulse; retry_count counts 1, 2, 3; fail=1 after the third timeout; pll_rst stays 0 thereafter.
- In STABILIZE, locked_in drops for 2 cycles at stable count 6 -> back to WAIT_LOCK; after locked_in returns, a full 8 stable cycles are required before RUN.
- In RUN, locked_in drops for 1 cycle -> sys_reset_n=0 three cycles later (2 sync + 1); relock_count=1; a 4-cycle pll_rst pulse follows, then a normal reacquire.
- From FAILED, restart pulse -> RESET_PLL on the next edge; retry_count=0; fail=0; lock then proceeds as in scenario 1. Repeat with restart during RUN -> relock_count unchanged.
- reset_n asserted mid-STABILIZE -> all outputs take reset values immediately (asynchronously). After release, the full sequence restarts with a 4-cycle pll_rst pulse.
